// File: rtl/ev_timer_pkg.sv
// Shared types for the event-timer result path: record struct, frame FSM states
// and byte-width helper used to size the serialized record.
package ev_timer_pkg;

  localparam int EV_ID_W = 3;
  localparam int EV_TS_W = 8;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  function automatic int bytes_of(input int w);
    return (w + 7) / 8;
  endfunction

  typedef struct packed {
    logic [EV_ID_W-1:0] id;
    logic [EV_TS_W-1:0] start_ts;
    logic [EV_TS_W-1:0] end_ts;
    logic [EV_TS_W-1:0] delta;
  } ev_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_REC,
    ST_GAP,
    ST_TRAILER
  } ev_state_t;

endpackage

// File: rtl/ev_rec_flatten.sv
// Turns one latency record into its big-endian byte image: id, start_ts, end_ts,
// delta, each field zero-padded up to a whole number of bytes.
module ev_rec_flatten
  import ev_timer_pkg::*;
#(
  localparam int IDB = bytes_of(EV_ID_W),
  localparam int TSB = bytes_of(EV_TS_W),
  localparam int RB  = IDB + 3 * TSB
) (
  input  ev_rec_t           rec_i,
  output logic [RB*8-1:0]   bytes_o
);

  logic [IDB*8-1:0] id_pad;
  logic [TSB*8-1:0] start_pad;
  logic [TSB*8-1:0] end_pad;
  logic [TSB*8-1:0] delta_pad;

  always_comb begin
    id_pad    = '0;
    start_pad = '0;
    end_pad   = '0;
    delta_pad = '0;
    id_pad[EV_ID_W-1:0]    = rec_i.id;
    start_pad[EV_TS_W-1:0] = rec_i.start_ts;
    end_pad[EV_TS_W-1:0]   = rec_i.end_ts;
    delta_pad[EV_TS_W-1:0] = rec_i.delta;
  end

  assign bytes_o = {id_pad, start_pad, end_pad, delta_pad};

endmodule

// File: rtl/ev_record_serializer.sv
// Packs latency records into byte frames: SYNC, SEQ, K records, K (tlast).
// A partial frame is closed when no record arrives within FLUSH_TIMEOUT cycles.
module ev_record_serializer
  import ev_timer_pkg::*;
#(
  parameter int         ID_W           = EV_ID_W,
  parameter int         TS_W           = EV_TS_W,
  parameter int         RECS_PER_FRAME = 4,
  parameter int         FLUSH_TIMEOUT  = 64,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ID_W-1:0] in_id,
  input  logic [TS_W-1:0] in_start_ts,
  input  logic [TS_W-1:0] in_end_ts,
  input  logic [TS_W-1:0] in_delta,
  output logic [7:0]      m_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            m_tlast,
  output logic            busy
);

  localparam int RB    = bytes_of(ID_W) + 3 * bytes_of(TS_W);
  localparam int IDX_W = $clog2(RB + 1);
  localparam int CNT_W = $clog2(FLUSH_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RB - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);
  localparam logic [7:0]       K_MAX    = 8'(RECS_PER_FRAME);

  ev_state_t        state_q, state_d;
  ev_rec_t          rec_q, rec_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       k_q, k_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic             tvalid_q, tvalid_d;
  logic             accept;
  logic [RB*8-1:0]  flat_d;

  function automatic logic [7:0] pick(input logic [RB*8-1:0] v, input logic [IDX_W-1:0] i);
    return v[8*(RB-1-int'(i)) +: 8];
  endfunction

  assign in_ready = ((state_q == ST_IDLE) || (state_q == ST_GAP)) && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);
  assign m_tdata  = tdata_q;
  assign m_tlast  = tlast_q;
  assign m_tvalid = tvalid_q;

  // The flattener sees the record as it will be held next cycle, so the first
  // record byte can be registered in the same cycle the record is accepted.
  always_comb begin
    rec_d = rec_q;
    if (accept) begin
      rec_d.id       = in_id;
      rec_d.start_ts = in_start_ts;
      rec_d.end_ts   = in_end_ts;
      rec_d.delta    = in_delta;
    end
  end

  ev_rec_flatten u_flatten (
    .rec_i   (rec_d),
    .bytes_o (flat_d)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    seq_d    = seq_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SYNC;
          k_d      = 8'd1;
          tdata_d  = SYNC_BYTE;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
        end
      end
      ST_SYNC: begin
        if (m_tready) begin
          state_d = ST_SEQ;
          tdata_d = seq_q;
        end
      end
      ST_SEQ: begin
        if (m_tready) begin
          state_d = ST_REC;
          idx_d   = '0;
          tdata_d = pick(flat_d, '0);
        end
      end
      ST_REC: begin
        if (m_tready) begin
          if (idx_q == LAST_IDX) begin
            if (k_q == K_MAX) begin
              state_d = ST_TRAILER;
              tdata_d = k_q;
              tlast_d = 1'b1;
            end else begin
              state_d  = ST_GAP;
              cnt_d    = '0;
              tvalid_d = 1'b0;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tdata_d = pick(flat_d, idx_q + 1'b1);
          end
        end
      end
      ST_GAP: begin
        // A record arriving on the expiry cycle still joins this frame.
        if (accept) begin
          state_d  = ST_REC;
          k_d      = k_q + 8'd1;
          idx_d    = '0;
          tdata_d  = pick(flat_d, '0);
          tvalid_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_TRAILER;
          tdata_d  = k_q;
          tlast_d  = 1'b1;
          tvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TRAILER: begin
        if (m_tready) begin
          state_d  = ST_IDLE;
          seq_d    = seq_q + 8'd1;
          tlast_d  = 1'b0;
          tvalid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rec_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      seq_q    <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rec_q    <= rec_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      seq_q    <= seq_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

endmodule
